// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the 16-bit word-addressed data memory and registers MEM/WB.
// Byte stores take two cycles (read, then write back the merged word) and stall upstream for the first one.
module mem_access_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [2:0]            ex_op,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic                  ex_byte_sel,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic [DATA_WIDTH-1:0] ex_alu,
  input  logic [REG_WIDTH-1:0]  ex_rd,
  input  logic                  ex_regwrite,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_WIDTH-1:0]  wb_rd,
  output logic                  wb_regwrite
);

  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  typedef enum logic {IDLE = 1'b0, SB_WR = 1'b1} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [REG_WIDTH-1:0]  hold_rd;

  logic [7:0]            sel_byte;
  logic [DATA_WIDTH-1:0] merged;

  assign sel_byte = ex_byte_sel ? mem_read_data[15:8] : mem_read_data[7:0];
  assign merged   = ex_byte_sel ? {ex_wdata[7:0], mem_read_data[7:0]}
                                : {mem_read_data[15:8], ex_wdata[7:0]};

  always_comb begin
    next_state     = state;
    stall          = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_address    = ex_addr;
    mem_write_data = ex_wdata;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          case (ex_op)
            OP_LW, OP_LB, OP_LBU: mem_rd = 1'b1;
            OP_SW:                mem_wr = 1'b1;
            OP_SB: begin
              mem_rd     = 1'b1;
              stall      = 1'b1;
              next_state = SB_WR;
            end
            default: ;
          endcase
        end
      end
      SB_WR: begin
        mem_wr         = 1'b1;
        mem_address    = hold_addr;
        mem_write_data = hold_data;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Keeps a reset landing in SB_WR from committing the half-finished byte store.
    if (!rst_n) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_addr   <= '0;
      hold_data   <= '0;
      hold_rd     <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          wb_valid    <= ex_valid;
          wb_data     <= ex_alu;
          wb_rd       <= ex_rd;
          wb_regwrite <= 1'b0;
          if (ex_valid) begin
            case (ex_op)
              OP_LW: begin
                wb_data     <= mem_read_data;
                wb_regwrite <= ex_regwrite;
              end
              OP_LB: begin
                wb_data     <= {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
                wb_regwrite <= ex_regwrite;
              end
              OP_LBU: begin
                wb_data     <= {{(DATA_WIDTH-8){1'b0}}, sel_byte};
                wb_regwrite <= ex_regwrite;
              end
              OP_SW: ;
              OP_SB: begin
                wb_valid  <= 1'b0;
                hold_addr <= ex_addr;
                hold_data <= merged;
                hold_rd   <= ex_rd;
              end
              default: wb_regwrite <= ex_regwrite;
            endcase
          end
        end
        SB_WR: begin
          wb_valid    <= 1'b1;
          wb_data     <= hold_data;
          wb_rd       <= hold_rd;
          wb_regwrite <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random instruction stream against an
// instruction-level reference model holding its own copy of memory.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [7:0]  ex_addr;
  logic        ex_byte_sel;
  logic [15:0] ex_wdata;
  logic [15:0] ex_alu;
  logic [2:0]  ex_rd;
  logic        ex_regwrite;
  logic        stall;
  logic [7:0]  mem_address;
  logic [15:0] mem_write_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [15:0] mem_read_data;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_regwrite;

  int checks = 0;
  int errors = 0;

  logic [15:0] env_mem [0:255];
  logic [15:0] ref_mem [0:255];

  always #5 clk = ~clk;

  assign mem_read_data = env_mem[mem_address];
  always @(posedge clk) if (mem_wr) env_mem[mem_address] <= mem_write_data;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
    .ex_byte_sel(ex_byte_sel), .ex_wdata(ex_wdata), .ex_alu(ex_alu), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .stall(stall), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_read_data(mem_read_data), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One instruction, started just after a rising edge; returns just after the edge
  // where its result is in MEM/WB.
  task automatic run(input logic v, input logic [2:0] op, input logic [7:0] addr,
                     input logic sel, input logic [15:0] wd, input logic [15:0] alu,
                     input logic [2:0] rd, input logic rw);
    int          kind;
    logic [15:0] word, expd, mrg;
    logic [7:0]  b;
    ex_valid = v; ex_op = op; ex_addr = addr; ex_byte_sel = sel;
    ex_wdata = wd; ex_alu = alu; ex_rd = rd; ex_regwrite = rw;
    kind = !v ? -1 : (op > 3'd5 ? 0 : int'(op));
    word = ref_mem[addr];
    b    = sel ? word[15:8] : word[7:0];
    case (kind)
      1:       expd = word;
      2:       expd = {{8{b[7]}}, b};
      3:       expd = {8'h00, b};
      default: expd = alu;
    endcase
    @(negedge clk);
    chk("mem_rd", mem_rd, kind inside {1, 2, 3, 5});
    chk("mem_wr", mem_wr, kind == 4);
    chk("stall", stall, kind == 5);
    if (kind >= 1) chk("mem_address", mem_address, addr);
    if (kind == 4) chk("mem_write_data", mem_write_data, wd);
    @(posedge clk); #1;
    if (kind == 5) begin
      chk("sb_bubble", wb_valid, 0);
      mrg = sel ? {wd[7:0], word[7:0]} : {word[15:8], wd[7:0]};
      @(negedge clk);
      chk("sb_mem_wr", mem_wr, 1);
      chk("sb_mem_rd", mem_rd, 0);
      chk("sb_stall", stall, 0);
      chk("sb_addr", mem_address, addr);
      chk("sb_wdata", mem_write_data, mrg);
      ref_mem[addr] = mrg;
      @(posedge clk); #1;
      chk("sb_wb_valid", wb_valid, 1);
      chk("sb_wb_regwrite", wb_regwrite, 0);
      chk("sb_wb_rd", wb_rd, rd);
    end else begin
      chk("wb_valid", wb_valid, v);
      chk("wb_regwrite", wb_regwrite, (kind >= 0 && kind <= 3) ? rw : 1'b0);
      if (v) chk("wb_rd", wb_rd, rd);
      if (kind >= 0 && kind <= 3) chk("wb_data", wb_data, expd);
      if (kind == 4) ref_mem[addr] = wd;
    end
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b1; ex_op = 3'b100; ex_addr = 8'd7; ex_byte_sel = 1'b0;
    ex_wdata = 16'hDEAD; ex_alu = 16'h0; ex_rd = 3'd1; ex_regwrite = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_stall", stall, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ex_valid = 1'b0;
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_regwrite", wb_regwrite, 0);
    chk("rst_stall_rel", stall, 0);
    @(posedge clk); #1;

    // byte loads of 0x00FF
    run(1, 3'b100, 8'd0, 0, 16'h00FF, 16'h0, 3'd0, 1);
    run(1, 3'b010, 8'd0, 0, 16'h0, 16'h0, 3'd3, 1);
    chk("lb0_value", wb_data, 16'hFFFF);
    run(1, 3'b011, 8'd0, 0, 16'h0, 16'h0, 3'd4, 1);
    chk("lbu0_value", wb_data, 16'h00FF);
    run(1, 3'b010, 8'd0, 1, 16'h0, 16'h0, 3'd5, 1);
    chk("lb1_value", wb_data, 16'h0000);

    // SB into upper lane, then read back
    run(1, 3'b100, 8'd1, 0, 16'h0053, 16'h0, 3'd0, 0);
    run(1, 3'b101, 8'd1, 1, 16'h12AB, 16'h0, 3'd2, 1);
    run(1, 3'b001, 8'd1, 0, 16'h0, 16'h0, 3'd6, 1);
    chk("sb_readback", wb_data, 16'hAB53);

    // SW then LW same address
    run(1, 3'b100, 8'd5, 0, 16'h1234, 16'h0, 3'd0, 1);
    run(1, 3'b001, 8'd5, 0, 16'h0, 16'h0, 3'd7, 1);
    chk("sw_lw_value", wb_data, 16'h1234);

    // SB followed by ALU op
    run(1, 3'b100, 8'd2, 0, 16'h7777, 16'h0, 3'd0, 0);
    run(1, 3'b101, 8'd2, 0, 16'h00C3, 16'h0, 3'd1, 1);
    run(1, 3'b000, 8'd0, 0, 16'h0, 16'h0042, 3'd2, 1);
    chk("alu_after_sb", wb_data, 16'h0042);

    // reset landing in SB_WR
    run(1, 3'b100, 8'd3, 0, 16'h5555, 16'h0, 3'd0, 0);
    ex_valid = 1'b1; ex_op = 3'b101; ex_addr = 8'd3; ex_byte_sel = 1'b0; ex_wdata = 16'h00AA;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_sbwr_mem_wr", mem_wr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_sbwr_mem", env_mem[3], 16'h5555);
    run(1, 3'b001, 8'd3, 0, 16'h0, 16'h0, 3'd3, 1);
    chk("rst_sbwr_lw", wb_data, 16'h5555);

    // random stream over a small address window
    for (int a = 0; a < 16; a++)
      run(1, 3'b100, 8'(a), 0, 16'($urandom), 16'h0, 3'd0, 0);
    for (int n = 0; n < 300; n++)
      run($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)),
          1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
    ex_valid = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) chk("final_mem", env_mem[a], ref_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the pipelined processor. It sits between the EX/MEM pipeline register and the 16-bit word-addressed data memory, and registers its result into the MEM/WB pipeline register. It supports word loads and stores plus signed and unsigned byte loads. Byte stores run as a two-cycle read-modify-write that stalls the upstream pipeline for one cycle.

## Interface
- DATA_WIDTH, 16, memory word width; fixed at 16 because byte lanes assume two bytes per word.
- ADDR_WIDTH, 8, word address width of the data memory.
- REG_WIDTH, 3, destination register index width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  EX/MEM holds a live instruction.
- ex_op  in  3  operation: 000 none/ALU, 001 LW, 010 LB (signed), 011 LBU, 100 SW, 101 SB; 110/111 treated as 000.
- ex_addr  in  ADDR_WIDTH  word address.
- ex_byte_sel  in  1  byte lane for LB/LBU/SB: 0 = [7:0], 1 = [15:8].
- ex_wdata  in  DATA_WIDTH  store data; SB uses [7:0] only.
- ex_alu  in  DATA_WIDTH  ALU result, forwarded for op 000.
- ex_rd  in  REG_WIDTH  destination register index.
- ex_regwrite  in  1  instruction writes the register file.
- stall  out  1  hold EX/MEM and all upstream stages this cycle.
- mem_address  out  ADDR_WIDTH  data memory address.
- mem_write_data  out  DATA_WIDTH  data memory write data.
- mem_wr  out  1  memory write enable.
- mem_rd  out  1  memory read enable.
- mem_read_data  in  DATA_WIDTH  memory read data; combinational from the address.
- wb_valid, wb_data, wb_rd, wb_regwrite  out  1/DATA_WIDTH/REG_WIDTH/1  MEM/WB register.

## Operation
- FSM states: IDLE and SB_WR.
- In IDLE, the memory port is driven combinationally from the ex_* inputs. In SB_WR, it is driven from the held registers.
- mem_rd and mem_wr are never both 1.
- Both mem_rd and mem_wr are forced to 0 while rst_n is low.
- **Bubble (ex_valid = 0):** mem_rd = mem_wr = 0. Next edge: wb_valid = 0 and wb_regwrite = 0.
- **ALU op:** no memory access. Next edge: wb_data = ex_alu, wb_valid = 1, wb_regwrite = ex_regwrite.
- **LW:** mem_rd = 1, mem_address = ex_addr. wb_data = mem_read_data.
- **LB:** wb_data = the selected byte, sign-extended to 16 bits.
- **LBU:** wb_data = the selected byte, zero-extended to 16 bits.
- **SW:** mem_wr = 1, mem_write_data = ex_wdata, single cycle. Next edge: wb_valid = 1, wb_regwrite = 0.
- **SB, cycle 1 (IDLE):**
  - Outputs: mem_rd = 1, stall = 1.
  - At the edge: latch the address, and latch the merged word (mem_read_data with the selected lane replaced by ex_wdata[7:0]) into the hold register.
  - Next state: SB_WR. wb_valid = 0 (bubble).
- **SB, cycle 2 (SB_WR):**
  - Outputs: mem_wr = 1, mem_address = held address, mem_write_data = merged word, stall = 0.
  - At the edge: wb_valid = 1, wb_regwrite = 0; state returns to IDLE.
  - ex_* inputs are ignored in this cycle (they still hold the SB instruction).
- wb_rd always takes ex_rd, or the held copy in SB_WR.
- Loads and the ALU op take ex_regwrite. Stores force wb_regwrite = 0.
- **Reset:** state = IDLE; all wb_* = 0; hold registers = 0; stall = 0.
- **Reset during SB_WR:** the write is abandoned and memory is unmodified.

## Timing
- Load, store, and ALU latency: 1 cycle (EX/MEM to MEM/WB).
- SB occupancy: 2 cycles, with stall high for exactly the first cycle.
- stall is combinational from state, ex_valid, and ex_op. It is high only in IDLE with a valid SB.
- mem_read_data is sampled at the same edge the read is issued (asynchronous-read memory).
- An instruction following an SB issues in the cycle after SB_WR.
- Back-to-back SB: stall pattern 1,0,1,0; one wb_valid per SB.
- Store then load to the same address: the store write lands at the edge, so the load in the next cycle sees the new data.

## Test plan
- Reset held 2 cycles with ex_valid = 1, op SW → mem_wr = 0 throughout; after release all wb_* = 0 and stall = 0.
- mem[0] = 0x00FF:
  - LB, byte_sel 0 → wb_data = 0xFFFF.
  - LBU, byte_sel 0 → wb_data = 0x00FF.
  - LB, byte_sel 1 → wb_data = 0x0000.
  - For all three: wb_regwrite = 1, rd propagated.
- mem[1] = 0x0053; SB, addr 1, byte_sel 1, wdata 0x12AB →
  - Cycle 1: stall = 1, mem_rd = 1.
  - Cycle 2: mem_wr = 1, mem_write_data = 0xAB53.
  - Then: LW addr 1 returns 0xAB53.
- SW addr 5 data 0x1234, then LW addr 5 the next cycle → wb_data = 0x1234, with no stall.
- SB addr 2, then ALU op with ex_alu = 0x0042 → the ALU result appears on wb exactly one cycle after the SB's wb_valid, with nothing lost or duplicated.
- SB started, rst_n low during SB_WR → mem_wr stays 0, memory word unchanged, state IDLE after release.
